ddr_cmd_scheduler: RTL and testbench

DDR_CMD_SCHEDULER -- requirements
Module: ddr_cmd_scheduler

---
 rtl/ddr_pkg.sv | 30 +++
 rtl/ddr_refresh_timer.sv | 37 +++
 rtl/ddr_cmd_scheduler.sv | 189 ++++++++++++++++++
 tb/tb_ddr_cmd_scheduler.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_pkg.sv
// Shared types and timing defaults for the DDR command scheduler.
package ddr_pkg;

  localparam int DATA_WIDTH  = 64;
  localparam int BURST_BEATS = 4;

  localparam int T_RCD_DEF  = 4;
  localparam int T_RP_DEF   = 4;
  localparam int T_RTP_DEF  = 3;
  localparam int T_WR_DEF   = 5;
  localparam int T_RFC_DEF  = 20;
  localparam int T_REFI_DEF = 200;
  localparam int CL_DEF     = 5;
  localparam int CWL_DEF    = 4;
  localparam int T_INIT_DEF = 16;

  typedef enum logic [3:0] {
    ST_INIT, ST_IDLE, ST_ACT, ST_TRCD, ST_RW,
    ST_RECOV, ST_PRE, ST_TRP, ST_REF, ST_TRFC
  } state_e;

  typedef enum logic [2:0] {
    CMD_DES, CMD_ACT, CMD_RD, CMD_WR, CMD_PRE, CMD_REF
  } cmd_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ddr_refresh_timer.sv
// Free-running refresh interval counter with a sticky single pending flag.
module ddr_refresh_timer
  import ddr_pkg::*;
#(
  parameter int T_REFI = T_REFI_DEF
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  input  logic i_clr,
  output logic o_pending
);

  localparam int CW = $clog2(T_REFI) + 1;
  localparam logic [CW-1:0] LAST = CW'(T_REFI - 1);

  logic [CW-1:0] r_cnt;
  logic          r_pending;
  logic          w_wrap;

  assign w_wrap = i_en && (r_cnt == LAST);

  // A wrap landing on the clearing REF cycle must not be lost, so set wins.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt     <= '0;
      r_pending <= 1'b0;
    end else begin
      if (i_en) r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
      if (w_wrap)     r_pending <= 1'b1;
      else if (i_clr) r_pending <= 1'b0;
    end
  end

  assign o_pending = r_pending;

endmodule

// File: rtl/ddr_cmd_scheduler.sv
// Single-request DDR4 command sequencer: ACT -> RD/WR -> PRE with periodic REF.
module ddr_cmd_scheduler
  import ddr_pkg::*;
#(
  parameter int T_RCD  = T_RCD_DEF,
  parameter int T_RP   = T_RP_DEF,
  parameter int T_RTP  = T_RTP_DEF,
  parameter int T_WR   = T_WR_DEF,
  parameter int T_RFC  = T_RFC_DEF,
  parameter int T_REFI = T_REFI_DEF,
  parameter int CL     = CL_DEF,
  parameter int CWL    = CWL_DEF,
  parameter int T_INIT = T_INIT_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_bg,
  input  logic [1:0]  req_ba,
  input  logic [13:0] req_row,
  input  logic [9:0]  req_col,
  output logic        CKE,
  output logic        cs_n,
  output logic        act_n,
  output logic        RAS_n_A16,
  output logic        CAS_n_A15,
  output logic        WE_n_A14,
  output logic        A17,
  output logic        A13,
  output logic        A12_BC_n,
  output logic        A11,
  output logic        A10_AP,
  output logic [9:0]  A9_A0,
  output logic [1:0]  bg_addr,
  output logic [1:0]  ba_addr,
  output logic        wr_data_en,
  output logic        rd_data_valid,
  output logic        busy
);

  localparam int T_WREC = CWL + BURST_BEATS + T_WR;
  localparam int T_MAX  = max_int(max_int(max_int(T_RCD, T_RP), max_int(T_RTP, T_WREC)),
                                  max_int(max_int(T_RFC, T_REFI), T_INIT));
  localparam int CW     = $clog2(T_MAX) + 1;

  // The command cycle itself counts toward its delay, so gaps after a command end one early.
  localparam logic [CW-1:0] LAST_INIT = CW'(T_INIT - 1);
  localparam logic [CW-1:0] LAST_TRCD = CW'(T_RCD - 2);
  localparam logic [CW-1:0] LAST_RTP  = CW'(T_RTP - 2);
  localparam logic [CW-1:0] LAST_WREC = CW'(T_WREC - 2);
  localparam logic [CW-1:0] LAST_TRP  = CW'(T_RP - 1);
  localparam logic [CW-1:0] LAST_TRFC = CW'(T_RFC - 1);

  state_e        r_state, w_next;
  cmd_e          w_cmd;
  logic [CW-1:0] r_cnt;
  logic          r_write;
  logic [1:0]    r_bg, r_ba;
  logic [13:0]   r_row;
  logic [9:0]    r_col;
  logic [CL+2:0]  r_rd_pipe;
  logic [CWL+2:0] r_wr_pipe;
  logic          w_pending, w_accept;

  ddr_refresh_timer #(.T_REFI(T_REFI)) u_refresh (
    .i_clk     (clk),
    .i_rst_n   (reset_n),
    .i_en      (r_state != ST_INIT),
    .i_clr     (r_state == ST_REF),
    .o_pending (w_pending)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_INIT;
      r_cnt     <= '0;
      r_write   <= 1'b0;
      r_bg      <= '0;
      r_ba      <= '0;
      r_row     <= '0;
      r_col     <= '0;
      r_rd_pipe <= '0;
      r_wr_pipe <= '0;
    end else begin
      r_state   <= w_next;
      r_cnt     <= (w_next != r_state) ? '0 : r_cnt + 1'b1;
      r_rd_pipe <= {r_rd_pipe[CL+1:0], w_cmd == CMD_RD};
      r_wr_pipe <= {r_wr_pipe[CWL+1:0], w_cmd == CMD_WR};
      if (w_accept) begin
        r_write <= req_write;
        r_bg    <= req_bg;
        r_ba    <= req_ba;
        r_row   <= req_row;
        r_col   <= req_col;
      end
    end
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    unique case (r_state)
      ST_INIT:  if (r_cnt == LAST_INIT) w_next = ST_IDLE;
      ST_IDLE: begin
        if (w_pending) w_next = ST_REF;
        else if (req_valid) begin
          w_accept = 1'b1;
          w_next   = ST_ACT;
        end
      end
      ST_ACT:   w_next = ST_TRCD;
      ST_TRCD:  if (r_cnt == LAST_TRCD) w_next = ST_RW;
      ST_RW:    w_next = ST_RECOV;
      ST_RECOV: if (r_cnt == (r_write ? LAST_WREC : LAST_RTP)) w_next = ST_PRE;
      ST_PRE:   w_next = ST_TRP;
      ST_TRP:   if (r_cnt == LAST_TRP) w_next = ST_IDLE;
      ST_REF:   w_next = ST_TRFC;
      ST_TRFC:  if (r_cnt == LAST_TRFC) w_next = ST_IDLE;
      default:  w_next = ST_INIT;
    endcase
  end

  always_comb begin
    w_cmd = CMD_DES;
    unique case (r_state)
      ST_ACT:  w_cmd = CMD_ACT;
      ST_RW:   w_cmd = r_write ? CMD_WR : CMD_RD;
      ST_PRE:  w_cmd = CMD_PRE;
      ST_REF:  w_cmd = CMD_REF;
      default: w_cmd = CMD_DES;
    endcase
  end

  always_comb begin
    cs_n      = 1'b1;
    act_n     = 1'b1;
    RAS_n_A16 = 1'b1;
    CAS_n_A15 = 1'b1;
    WE_n_A14  = 1'b1;
    A17       = 1'b0;
    A13       = 1'b0;
    A12_BC_n  = 1'b0;
    A11       = 1'b0;
    A10_AP    = 1'b0;
    A9_A0     = '0;
    bg_addr   = '0;
    ba_addr   = '0;
    unique case (w_cmd)
      CMD_ACT: begin
        cs_n  = 1'b0;
        act_n = 1'b0;
        {A13, A12_BC_n, A11, A10_AP, A9_A0} = r_row;
        bg_addr = r_bg;
        ba_addr = r_ba;
      end
      CMD_RD, CMD_WR: begin
        cs_n      = 1'b0;
        CAS_n_A15 = 1'b0;
        WE_n_A14  = (w_cmd != CMD_WR);
        A12_BC_n  = 1'b1;
        A9_A0     = r_col;
        bg_addr   = r_bg;
        ba_addr   = r_ba;
      end
      CMD_PRE: begin
        cs_n      = 1'b0;
        RAS_n_A16 = 1'b0;
        WE_n_A14  = 1'b0;
        bg_addr   = r_bg;
        ba_addr   = r_ba;
      end
      CMD_REF: begin
        cs_n      = 1'b0;
        RAS_n_A16 = 1'b0;
        CAS_n_A15 = 1'b0;
      end
      default: ;
    endcase
  end

  assign CKE           = (r_state != ST_INIT);
  assign busy          = (r_state != ST_IDLE);
  assign req_ready     = (r_state == ST_IDLE) && !w_pending;
  assign rd_data_valid = |r_rd_pipe[CL+2:CL-1];
  assign wr_data_en    = |r_wr_pipe[CWL+2:CWL-1];

endmodule

// File: tb/tb_ddr_cmd_scheduler.sv
// Self-checking bench: cycle-schedule model of the command timeline plus directed timing checks.
module tb_ddr_cmd_scheduler;

  localparam int T_RCD = 4, T_RP = 4, T_RTP = 3, T_WR = 5, T_RFC = 20;
  localparam int T_REFI = 200, CL = 5, CWL = 4, T_INIT = 16;
  localparam int K_DES = 0, K_ACT = 1, K_RD = 2, K_WR = 3, K_PRE = 4, K_REF = 5, K_BAD = 9;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [1:0]  req_bg = '0, req_ba = '0;
  logic [13:0] req_row = '0;
  logic [9:0]  req_col = '0;
  logic        req_ready, CKE, cs_n, act_n, RAS_n_A16, CAS_n_A15, WE_n_A14;
  logic        A17, A13, A12_BC_n, A11, A10_AP, wr_data_en, rd_data_valid, busy;
  logic [9:0]  A9_A0;
  logic [1:0]  bg_addr, ba_addr;

  ddr_cmd_scheduler #(
    .T_RCD(T_RCD), .T_RP(T_RP), .T_RTP(T_RTP), .T_WR(T_WR), .T_RFC(T_RFC),
    .T_REFI(T_REFI), .CL(CL), .CWL(CWL), .T_INIT(T_INIT)
  ) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_bg(req_bg), .req_ba(req_ba), .req_row(req_row),
    .req_col(req_col), .CKE(CKE), .cs_n(cs_n), .act_n(act_n), .RAS_n_A16(RAS_n_A16),
    .CAS_n_A15(CAS_n_A15), .WE_n_A14(WE_n_A14), .A17(A17), .A13(A13),
    .A12_BC_n(A12_BC_n), .A11(A11), .A10_AP(A10_AP), .A9_A0(A9_A0),
    .bg_addr(bg_addr), .ba_addr(ba_addr), .wr_data_en(wr_data_en),
    .rd_data_valid(rd_data_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0, gc = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, gc);
  endtask

  // Pin vector: {CKE, cs_n, act_n, RAS, CAS, WE, A17, A13, A12, A11, A10, A9_A0, bg, ba}
  function automatic logic [24:0] exp_pins(input int k, input bit cke, input logic [1:0] bg,
                                           input logic [1:0] ba, input logic [13:0] row,
                                           input logic [9:0] col);
    logic [4:0]  c;
    logic [14:0] ad;
    logic [3:0]  gb;
    c = 5'b11111; ad = '0; gb = '0;
    case (k)
      K_ACT: begin c = 5'b00111; ad = {1'b0, row};       gb = {bg, ba}; end
      K_RD:  begin c = 5'b01101; ad = {5'b00100, col};   gb = {bg, ba}; end
      K_WR:  begin c = 5'b01100; ad = {5'b00100, col};   gb = {bg, ba}; end
      K_PRE: begin c = 5'b01010;                          gb = {bg, ba}; end
      K_REF: begin c = 5'b01001; end
      default: ;
    endcase
    return {cke, c, ad, gb};
  endfunction

  function automatic int decode(input logic [24:0] p);
    if (p[23]) return K_DES;
    if (!p[22]) return K_ACT;
    case (p[21:19])
      3'b101:  return K_RD;
      3'b100:  return K_WR;
      3'b010:  return K_PRE;
      3'b001:  return K_REF;
      default: return K_BAD;
    endcase
  endfunction

  logic [24:0] w_pins;
  assign w_pins = {CKE, cs_n, act_n, RAS_n_A16, CAS_n_A15, WE_n_A14, A17, A13, A12_BC_n,
                   A11, A10_AP, A9_A0, bg_addr, ba_addr};

  // Model state: cycle index since reset release and a per-cycle expected schedule.
  int mc = 0, m_idle_from = T_INIT, m_ref_at = -1;
  bit m_pend = 0;
  logic [24:0] sched[int];
  bit rdv_at[int], wde_at[int];

  int obs_cke_rise = -1, obs_ready_rise_mc = -1, obs_ready_rise = 0;
  int obs_act = 0, obs_rw = 0, obs_pre = 0, obs_ref = 0, obs_ref_mc = 0;
  int obs_rdv_first = 0, obs_rdv_last = 0, obs_wde_first = 0, obs_wde_last = 0;
  int obs_rw_cnt = 0, obs_adj = 0, prev_kind = 0;
  logic [13:0] obs_act_row = '0;
  logic [3:0]  obs_act_bgba = '0;
  logic [9:0]  obs_rw_col = '0;
  bit prev_ready = 0, prev_rdv = 0, prev_wde = 0, prev_cke = 0;
  int act_q[$];

  always @(negedge clk) begin : mon
    logic [24:0] e;
    bit idle;
    int k, a, rw, pre;
    gc++;
    k = decode(w_pins);
    if (k != K_DES && prev_kind != K_DES) obs_adj++;
    if (!reset_n) begin
      chk("reset_pins", w_pins, exp_pins(K_DES, 1'b0, '0, '0, '0, '0));
      chk("reset_ready", req_ready, 1'b0);
      chk("reset_busy", busy, 1'b1);
      chk("reset_rdv", rd_data_valid, 1'b0);
      chk("reset_wde", wr_data_en, 1'b0);
      mc = 0; m_pend = 0; m_idle_from = T_INIT; m_ref_at = -1;
      sched.delete(); rdv_at.delete(); wde_at.delete();
    end else begin
      if (CKE && !prev_cke) obs_cke_rise = mc;
      if (req_ready && !prev_ready) begin obs_ready_rise = gc; obs_ready_rise_mc = mc; end
      case (k)
        K_ACT: begin
          obs_act = gc; act_q.push_back(gc);
          obs_act_row = {A13, A12_BC_n, A11, A10_AP, A9_A0};
          obs_act_bgba = {bg_addr, ba_addr};
        end
        K_RD, K_WR: begin obs_rw = gc; obs_rw_col = A9_A0; obs_rw_cnt++; end
        K_PRE: obs_pre = gc;
        K_REF: begin obs_ref = gc; obs_ref_mc = mc; end
        default: ;
      endcase
      if (rd_data_valid && !prev_rdv) obs_rdv_first = gc;
      if (rd_data_valid) obs_rdv_last = gc;
      if (wr_data_en && !prev_wde) obs_wde_first = gc;
      if (wr_data_en) obs_wde_last = gc;

      if (mc > T_INIT && ((mc - T_INIT) % T_REFI) == 0) m_pend = 1;
      idle = (mc >= m_idle_from);
      e = sched.exists(mc) ? sched[mc] : exp_pins(K_DES, mc >= T_INIT, '0, '0, '0, '0);
      chk("pins", w_pins, e);
      chk("req_ready", req_ready, idle && !m_pend);
      chk("busy", busy, !idle);
      chk("rd_data_valid", rd_data_valid, rdv_at.exists(mc));
      chk("wr_data_en", wr_data_en, wde_at.exists(mc));
      if (mc == m_ref_at) m_pend = 0;
      if (idle) begin
        if (m_pend) begin
          sched[mc+1] = exp_pins(K_REF, 1'b1, '0, '0, '0, '0);
          m_ref_at = mc + 1;
          m_idle_from = mc + 2 + T_RFC;
        end else if (req_valid) begin
          a   = mc + 1;
          rw  = a + T_RCD;
          pre = rw + (req_write ? CWL + 4 + T_WR : T_RTP);
          sched[a]   = exp_pins(K_ACT, 1'b1, req_bg, req_ba, req_row, req_col);
          sched[rw]  = exp_pins(req_write ? K_WR : K_RD, 1'b1, req_bg, req_ba, req_row, req_col);
          sched[pre] = exp_pins(K_PRE, 1'b1, req_bg, req_ba, req_row, req_col);
          for (int i = 0; i < 4; i++) begin
            if (req_write) wde_at[rw + CWL + i] = 1;
            else           rdv_at[rw + CL + i] = 1;
          end
          m_idle_from = pre + T_RP + 1;
        end
      end
      mc++;
    end
    prev_kind = k; prev_ready = req_ready && reset_n; prev_rdv = rd_data_valid;
    prev_wde = wr_data_en; prev_cke = CKE;
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input bit w, input logic [1:0] bg, input logic [1:0] ba,
                      input logic [13:0] row, input logic [9:0] col, output bit ok);
    req_write = w; req_bg = bg; req_ba = ba; req_row = row; req_col = col;
    req_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      if (req_ready) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
  endtask

  initial begin
    bit ok;
    int rw_snap;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    wait_cycles(20);
    chk("init_cke_rise_cycle", obs_cke_rise, 16);
    chk("init_first_ready_cycle", obs_ready_rise_mc, 16);

    send(1'b0, 2'd1, 2'd2, 14'h1ABC, 10'h03F, ok);
    chk("read_accept", ok, 1'b1);
    wait_cycles(16);
    chk("read_act_row", obs_act_row, 14'h1ABC);
    chk("read_act_bgba", obs_act_bgba, 4'b0110);
    chk("read_rd_delay", obs_rw - obs_act, 4);
    chk("read_rd_col", obs_rw_col, 10'h03F);
    chk("read_pre_delay", obs_pre - obs_act, 7);
    chk("read_rdv_first", obs_rdv_first - obs_act, 9);
    chk("read_rdv_last", obs_rdv_last - obs_act, 12);
    chk("read_ready_again", obs_ready_rise - obs_act, 12);

    send(1'b1, 2'd0, 2'd0, 14'd5, 10'd8, ok);
    chk("write_accept", ok, 1'b1);
    wait_cycles(26);
    chk("write_act_row", obs_act_row, 14'd5);
    chk("write_wr_delay", obs_rw - obs_act, 4);
    chk("write_wr_col", obs_rw_col, 10'd8);
    chk("write_wde_first", obs_wde_first - obs_act, 8);
    chk("write_wde_last", obs_wde_last - obs_act, 11);
    chk("write_pre_delay", obs_pre - obs_act, 17);

    do @(posedge clk); while (mc < T_INIT + T_REFI);
    #1;
    send(1'b0, 2'd3, 2'd1, 14'h2000, 10'h155, ok);
    chk("refresh_held_accept", ok, 1'b1);
    wait_cycles(16);
    chk("refresh_ref_cycle", obs_ref_mc, 217);
    chk("refresh_then_act", obs_act - obs_ref, 22);

    send(1'b0, 2'd2, 2'd3, 14'h0777, 10'h0AA, ok);
    chk("abort_accept", ok, 1'b1);
    @(posedge clk);
    #1;
    rw_snap = obs_rw_cnt;
    reset_n = 1'b0;
    #1;
    chk("abort_async_cke", CKE, 1'b0);
    chk("abort_async_cs_n", cs_n, 1'b1);
    chk("abort_async_busy", busy, 1'b1);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    wait_cycles(40);
    chk("abort_no_rw_after", obs_rw_cnt - rw_snap, 0);

    act_q.delete();
    send(1'b0, 2'd1, 2'd1, 14'h0011, 10'h001, ok);
    chk("b2b_accept0", ok, 1'b1);
    send(1'b0, 2'd2, 2'd2, 14'h0022, 10'h002, ok);
    chk("b2b_accept1", ok, 1'b1);
    send(1'b1, 2'd3, 2'd3, 14'h0033, 10'h003, ok);
    chk("b2b_accept2", ok, 1'b1);
    wait_cycles(30);
    chk("b2b_act_count", act_q.size(), 3);
    if (act_q.size() >= 3) begin
      chk("b2b_gap_rd_rd", act_q[1] - act_q[0], 13);
      chk("b2b_gap_rd_wr", act_q[2] - act_q[1], 13);
    end

    do @(posedge clk); while (mc < 430);
    #1;
    chk("no_adjacent_cmds", obs_adj, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
